// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Instruction field positions, stage control/content types and
//            bubble constants shared by the pipeline register slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mips_pkg;

  localparam int REG_W = 5;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef struct packed {
    logic regdst;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  // ID/EX keeps the already-selected destination, so regdst is consumed at entry.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dst;
    mem_ctrl_t        mem;
    wb_ctrl_t         wb;
  } idex_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    wb_ctrl_t         wb;
  } exmem_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    wb_ctrl_t         wb;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  function automatic logic [REG_W-1:0] sel_dst(
    input ex_ctrl_t         ex,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd
  );
    return ex.regdst ? rd : rt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_regs_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_regs.sv
// ============================================================================
// Module   : pipe_stage_regs
// Brief    : IF/ID, ID/EX, EX/MEM, MEM/WB registers of the 5-stage core with
//            stall/flush handling and saturating stall/flush event counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pipe_stage_regs
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_valid,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_regdst,
  input  logic             stall,
  input  logic             flush,
  output logic [XLEN-1:0]  ifid_instr,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [4:0]       ifid_rs,
  output logic [4:0]       ifid_rt,
  output logic [4:0]       idex_rs,
  output logic [4:0]       idex_rt,
  output logic             idex_memread,
  output logic [4:0]       idex_dst,
  output logic             exmem_regwrite,
  output logic [4:0]       exmem_rd,
  output logic             exmem_memtoreg,
  output logic             memwb_regwrite,
  output logic [4:0]       memwb_rd,
  output logic             memwb_memtoreg,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0] r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;
  logic            r_ifid_valid;
  idex_t           r_idex;
  exmem_t          r_exmem;
  memwb_t          r_memwb;

  logic            w_stall_only;
  logic [XLEN-1:0] w_ifid_instr_nxt;
  ex_ctrl_t        w_ex_ctrl;
  idex_t           w_idex_nxt;
  exmem_t          w_exmem_nxt;
  memwb_t          w_memwb_nxt;

  // A flush overrides a stall: the stalled instruction is on the wrong path anyway.
  assign w_stall_only     = stall & ~flush;
  assign w_ifid_instr_nxt = if_valid ? if_instr : '0;

  assign w_ex_ctrl.regdst = id_regdst;

  always_comb begin
    w_idex_nxt              = IDEX_BUBBLE;
    w_idex_nxt.valid        = r_ifid_valid;
    w_idex_nxt.rs           = r_ifid_instr[RS_HI:RS_LO];
    w_idex_nxt.rt           = r_ifid_instr[RT_HI:RT_LO];
    w_idex_nxt.dst          = sel_dst(w_ex_ctrl, r_ifid_instr[RT_HI:RT_LO],
                                      r_ifid_instr[RD_HI:RD_LO]);
    w_idex_nxt.mem.memread  = id_memread  & r_ifid_valid;
    w_idex_nxt.wb.regwrite  = id_regwrite & r_ifid_valid;
    w_idex_nxt.wb.memtoreg  = id_memtoreg & r_ifid_valid;
  end

  always_comb begin
    w_exmem_nxt       = EXMEM_BUBBLE;
    w_exmem_nxt.valid = r_idex.valid;
    w_exmem_nxt.rd    = r_idex.dst;
    w_exmem_nxt.wb    = r_idex.wb;
  end

  always_comb begin
    w_memwb_nxt       = MEMWB_BUBBLE;
    w_memwb_nxt.valid = r_exmem.valid;
    w_memwb_nxt.rd    = r_exmem.rd;
    w_memwb_nxt.wb    = r_exmem.wb;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= if_pc;
      r_ifid_valid <= if_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex  <= IDEX_BUBBLE;
      r_exmem <= EXMEM_BUBBLE;
      r_memwb <= MEMWB_BUBBLE;
    end else begin
      r_idex  <= (stall || flush) ? IDEX_BUBBLE : w_idex_nxt;
      r_exmem <= w_exmem_nxt;
      r_memwb <= w_memwb_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall_only),
    .o_count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (flush),
    .o_count (flush_cnt)
  );

  assign pc_write       = ~w_stall_only;
  assign ifid_write     = ~w_stall_only;

  assign ifid_instr     = r_ifid_instr;
  assign ifid_pc        = r_ifid_pc;
  assign ifid_rs        = r_ifid_instr[RS_HI:RS_LO];
  assign ifid_rt        = r_ifid_instr[RT_HI:RT_LO];

  assign idex_rs        = r_idex.rs;
  assign idex_rt        = r_idex.rt;
  assign idex_memread   = r_idex.mem.memread;
  assign idex_dst       = r_idex.dst;

  assign exmem_regwrite = r_exmem.valid & r_exmem.wb.regwrite;
  assign exmem_memtoreg = r_exmem.valid & r_exmem.wb.memtoreg;
  assign exmem_rd       = r_exmem.rd;

  assign memwb_regwrite = r_memwb.valid & r_memwb.wb.regwrite;
  assign memwb_memtoreg = r_memwb.valid & r_memwb.wb.memtoreg;
  assign memwb_rd       = r_memwb.rd;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
// ============================================================================
// Module   : tb_pipe_stage_regs
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against an instruction-record pipeline model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_stage_regs;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [31:0] I_ADD  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] I_LW   = 32'h8C25_0000; // lw  $5,0($1)
  localparam logic [31:0] I_ADD2 = 32'h00A7_3020; // add $6,$5,$7
  localparam logic [31:0] I_BEQ  = 32'h1022_0004; // beq $1,$2,4

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [XLEN-1:0]  if_instr, if_pc;
  logic             if_valid, id_regwrite, id_memread, id_memtoreg, id_regdst;
  logic             stall, flush;
  logic [XLEN-1:0]  ifid_instr, ifid_pc;
  logic [4:0]       ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dst, exmem_rd, memwb_rd;
  logic             idex_memread, exmem_regwrite, exmem_memtoreg;
  logic             memwb_regwrite, memwb_memtoreg, pc_write, ifid_write;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_stage_regs #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_regdst(id_regdst),
    .stall(stall), .flush(flush),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memread(idex_memread), .idex_dst(idex_dst),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_memtoreg(exmem_memtoreg),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .memwb_memtoreg(memwb_memtoreg),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction record per stage; the whole instruction travels along.
  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rw, mr, mtr, rdst;
  } rec_t;

  rec_t m_if, m_id, m_ex, m_wb;
  int   m_scnt, m_fcnt;

  function automatic logic [4:0] dst_of(input rec_t r);
    logic [31:0] ins;
    ins = r.instr;
    return r.rdst ? ins[15:11] : ins[20:16];
  endfunction

  always @(posedge clk) begin
    rec_t nif, nid;
    if (rst) begin
      m_if = '0; m_id = '0; m_ex = '0; m_wb = '0;
      m_scnt = 0; m_fcnt = 0;
    end else begin
      nif = '0;
      if (!flush && stall) nif = m_if;
      else if (!flush) begin
        nif.v     = if_valid;
        nif.instr = if_valid ? if_instr : 32'h0;
        nif.pc    = if_pc;
      end
      nid = '0;
      if (!flush && !stall) begin
        nid      = m_if;
        nid.rw   = id_regwrite & m_if.v;
        nid.mr   = id_memread  & m_if.v;
        nid.mtr  = id_memtoreg & m_if.v;
        nid.rdst = id_regdst;
      end
      m_wb = m_ex;
      m_ex = m_id;
      m_id = nid;
      m_if = nif;
      if (flush)      m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      else if (stall) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ifid_instr",     ifid_instr,     m_if.instr);
      check("ifid_pc",        ifid_pc,        m_if.pc);
      check("ifid_rs",        32'(ifid_rs),   32'(m_if.instr[25:21]));
      check("ifid_rt",        32'(ifid_rt),   32'(m_if.instr[20:16]));
      check("idex_rs",        32'(idex_rs),   32'(m_id.instr[25:21]));
      check("idex_rt",        32'(idex_rt),   32'(m_id.instr[20:16]));
      check("idex_memread",   32'(idex_memread), 32'(m_id.mr));
      check("idex_dst",       32'(idex_dst),  32'(dst_of(m_id)));
      check("exmem_regwrite", 32'(exmem_regwrite), 32'(m_ex.rw));
      check("exmem_memtoreg", 32'(exmem_memtoreg), 32'(m_ex.mtr));
      check("exmem_rd",       32'(exmem_rd),  32'(dst_of(m_ex)));
      check("memwb_regwrite", 32'(memwb_regwrite), 32'(m_wb.rw));
      check("memwb_memtoreg", 32'(memwb_memtoreg), 32'(m_wb.mtr));
      check("memwb_rd",       32'(memwb_rd),  32'(dst_of(m_wb)));
      check("pc_write",       32'(pc_write),   32'(!(stall && !flush)));
      check("ifid_write",     32'(ifid_write), 32'(!(stall && !flush)));
      check("stall_cnt",      32'(stall_cnt), 32'(m_scnt));
      check("flush_cnt",      32'(flush_cnt), 32'(m_fcnt));
    end
  end

  logic [31:0] pc_ctr = 32'h0000_0400;

  // ctl = {regwrite, memread, memtoreg, regdst}
  task automatic drive(input logic [31:0] instr, input logic v, input logic [3:0] ctl,
                       input logic st, input logic fl);
    if_instr    = instr;
    if_valid    = v;
    if_pc       = pc_ctr;
    pc_ctr      = pc_ctr + 32'd4;
    id_regwrite = ctl[3];
    id_memread  = ctl[2];
    id_memtoreg = ctl[1];
    id_regdst   = ctl[0];
    stall       = st;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add_stream(input string tag);
    drive(I_ADD, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
    check({tag, "_ifid_rs"}, 32'(ifid_rs), 32'd1);
    check({tag, "_ifid_rt"}, 32'(ifid_rt), 32'd2);
    drive(32'h0, 1'b0, 4'b1001, 1'b0, 1'b0); tick();
    check({tag, "_idex_dst"}, 32'(idex_dst), 32'd3);
    drive(32'h0, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
    check({tag, "_exmem_rd"}, 32'(exmem_rd), 32'd3);
    check({tag, "_exmem_rw"}, 32'(exmem_regwrite), 32'd1);
    tick();
    check({tag, "_memwb_rd"}, 32'(memwb_rd), 32'd3);
    check({tag, "_memwb_rw"}, 32'(memwb_regwrite), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick(); tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_ifid_instr", ifid_instr, 32'h0);
    check("rst_idex_dst",   32'(idex_dst), 32'h0);
    check("rst_exmem_rw",   32'(exmem_regwrite), 32'h0);
    check("rst_memwb_rd",   32'(memwb_rd), 32'h0);
    check("rst_stall_cnt",  32'(stall_cnt), 32'h0);
    check("rst_flush_cnt",  32'(flush_cnt), 32'h0);

    add_stream("adv");

    // load-use stall with lw in ID/EX
    drive(I_LW, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
    drive(I_ADD2, 1'b1, 4'b1110, 1'b0, 1'b0); tick();
    check("lw_idex_memread", 32'(idex_memread), 32'd1);
    check("lw_idex_dst",     32'(idex_dst), 32'd5);
    drive(32'h1111_1111, 1'b1, 4'b1001, 1'b1, 1'b0);
    #1;
    check("stall_pc_write",   32'(pc_write), 32'd0);
    check("stall_ifid_write", 32'(ifid_write), 32'd0);
    tick();
    check("stall_ifid_hold",  ifid_instr, I_ADD2);
    check("stall_idex_mr",    32'(idex_memread), 32'd0);
    check("stall_idex_dst",   32'(idex_dst), 32'd0);
    check("stall_exmem_rd",   32'(exmem_rd), 32'd5);
    check("stall_exmem_mtr",  32'(exmem_memtoreg), 32'd1);
    check("stall_cnt_1",      32'(stall_cnt), 32'd1);
    drive(32'h1111_1111, 1'b1, 4'b1001, 1'b0, 1'b0); tick();
    check("resume_idex_dst",  32'(idex_dst), 32'd6);
    check("resume_memwb_rd",  32'(memwb_rd), 32'd5);

    // branch flush with beq in ID/EX
    drive(I_BEQ, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
    drive(32'h2222_2222, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
    check("beq_idex_dst", 32'(idex_dst), 32'd2);
    drive(32'h3333_3333, 1'b1, 4'b0100, 1'b0, 1'b1);
    #1;
    check("flush_pc_write", 32'(pc_write), 32'd1);
    tick();
    check("flush_ifid_instr", ifid_instr, 32'h0);
    check("flush_ifid_pc",    ifid_pc, 32'h0);
    check("flush_idex_dst",   32'(idex_dst), 32'd0);
    check("flush_exmem_rd",   32'(exmem_rd), 32'd2);
    check("flush_exmem_rw",   32'(exmem_regwrite), 32'd0);
    check("flush_cnt_1",      32'(flush_cnt), 32'd1);
    drive(32'h4444_4444, 1'b1, 4'b1101, 1'b0, 1'b0); tick();
    check("flush_valid_gate", 32'(idex_memread), 32'd0);

    // stall and flush together
    drive(32'h5555_5555, 1'b1, 4'b0000, 1'b1, 1'b1);
    #1;
    check("both_pc_write", 32'(pc_write), 32'd1);
    tick();
    check("both_stall_cnt",  32'(stall_cnt), 32'd1);
    check("both_flush_cnt",  32'(flush_cnt), 32'd2);
    check("both_ifid_instr", ifid_instr, 32'h0);

    // counter saturation
    for (int i = 0; i < 20; i++) begin
      drive(32'h6666_6666, 1'b1, 4'b0000, 1'b1, 1'b0); tick();
    end
    check("sat_stall_cnt", 32'(stall_cnt), CMAX);
    tick();
    check("sat_stall_hold", 32'(stall_cnt), CMAX);

    // reset mid-stream with a full pipe and stall asserted
    for (int i = 0; i < 4; i++) begin
      drive(I_ADD, 1'b1, 4'b1011, 1'b0, 1'b0); tick();
    end
    check("full_memwb_rd", 32'(memwb_rd), 32'd3);
    rst = 1'b1;
    drive(I_ADD, 1'b1, 4'b1011, 1'b1, 1'b0); tick();
    rst = 1'b0;
    check("mrst_ifid_instr", ifid_instr, 32'h0);
    check("mrst_idex_dst",   32'(idex_dst), 32'd0);
    check("mrst_exmem_rd",   32'(exmem_rd), 32'd0);
    check("mrst_memwb_rd",   32'(memwb_rd), 32'd0);
    check("mrst_memwb_mtr",  32'(memwb_memtoreg), 32'd0);
    check("mrst_stall_cnt",  32'(stall_cnt), 32'd0);
    add_stream("refill");

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      tick();
    end
    rst = 1'b0;
    drive(32'h0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Holds the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core: instruction/PC, per-stage valid, control bits, register specifiers.
- Produces the register-specifier and control fields that the forwarding and hazard logic read.
- Applies the stall and flush requests that come back from that logic and from branch resolution.
- Carries a saturating stall/flush event counter for performance debug.

Parameters:
- XLEN, 32, PC and instruction width.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_instr  in  XLEN  fetched instruction
- if_pc  in  XLEN  PC of the fetched instruction
- if_valid  in  1  fetched instruction valid
- id_regwrite  in  1  decoder control for the instruction in IF/ID
- id_memread  in  1  decoder control for the instruction in IF/ID
- id_memtoreg  in  1  decoder control for the instruction in IF/ID
- id_regdst  in  1  1 selects rd, 0 selects rt as destination
- stall  in  1  load-use stall request
- flush  in  1  branch taken in EX
- ifid_instr  out  XLEN  IF/ID instruction
- ifid_pc  out  XLEN  IF/ID PC
- ifid_rs  out  5  instr[25:21] of IF/ID
- ifid_rt  out  5  instr[20:16] of IF/ID
- idex_rs  out  5  ID/EX source
- idex_rt  out  5  ID/EX source
- idex_memread  out  1  ID/EX control
- idex_dst  out  5  ID/EX destination
- exmem_regwrite  out  1  EX/MEM control
- exmem_rd  out  5  EX/MEM destination
- exmem_memtoreg  out  1  EX/MEM control
- memwb_regwrite  out  1  MEM/WB control
- memwb_rd  out  5  MEM/WB destination
- memwb_memtoreg  out  1  MEM/WB control
- pc_write  out  1  PC update enable (combinational)
- ifid_write  out  1  IF/ID load enable (combinational)
- stall_cnt  out  CNT_W  count of stall cycles
- flush_cnt  out  CNT_W  count of flush cycles

Behaviour:
- Reset (rst=1 at posedge):
  - All stage registers, valid bits and both counters clear to 0.
  - A bubble is the all-zero stage content: valid=0, specifiers=0, controls=0. Every register/control output therefore reads 0 after reset.
  - Reset wins over stall/flush in the same cycle.
- Destination selection: ID/EX dst = id_regdst ? ifid_instr[15:11] : ifid_instr[20:16].
- Control gating at entry:
  - Controls entering ID/EX are ANDed with IF/ID valid.
  - Controls entering IF/ID are gated by if_valid; when if_valid=0 the instruction field is loaded as 0.
- Normal advance (stall=0, flush=0), one cycle per stage:
  - IF/ID <- fetch.
  - ID/EX <- IF/ID plus decoded controls.
  - EX/MEM <- ID/EX.
  - MEM/WB <- EX/MEM.
- Stall (stall=1, flush=0):
  - pc_write=0, ifid_write=0; IF/ID holds.
  - ID/EX loads a bubble.
  - EX/MEM and MEM/WB advance.
  - stall_cnt increments.
- Flush (flush=1):
  - IF/ID and ID/EX both load bubbles.
  - EX/MEM receives the branch from ID/EX as normal; MEM/WB advances.
  - pc_write=1, ifid_write=1.
  - flush_cnt increments.
- Simultaneous stall and flush: flush has priority. Only flush_cnt increments.
- Combinational enables: pc_write = ifid_write = !(stall && !flush).
- Read-only fields: ifid_rs and ifid_rt are raw instruction fields, valid or not. The consumer qualifies them.
- Counters saturate at all-ones and do not wrap.
- rd=0 handling: no special treatment here. Downstream logic ignores register 0.
- No state machine beyond the stage registers. Latency from fetch to MEM/WB output is 4 cycles when no stall or flush occurs.

Decomposition:
- Shared package mips_pkg:
  - Instruction field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO).
  - Stage control struct types (ex_ctrl_t, mem_ctrl_t, wb_ctrl_t).
  - BUBBLE constants.
- One natural sub-module: sat_counter (CNT_W parameter, inc enable, sync reset), instantiated twice.

Test Plan:
- Reset → advance: assert rst for 2 cycles, then stream add $3,$1,$2 (regdst=1, regwrite=1) with if_valid=1 → exactly 3 posedges later exmem_rd=3 and exmem_regwrite=1; one cycle after that memwb_rd=3.
- Stall:
  - Stimulus: lw $5,0($1) in ID/EX; stall=1 for 1 cycle.
  - Response: pc_write=0 and ifid_write=0 in that cycle; IF/ID instr unchanged next cycle; idex_memread=0 and idex_dst=0 next cycle; lw reaches EX/MEM; stall_cnt=1.
- Flush: flush=1 for 1 cycle → next cycle ifid_instr=0, IF/ID valid=0, idex_dst=0; the branch appears in EX/MEM; flush_cnt=1; pc_write=1.
- Stall and flush together: stall=1 and flush=1 → flush behaviour as above; stall_cnt unchanged; pc_write=1.
- Counter saturation: CNT_W=4, stall held for 20 cycles → stall_cnt reaches 15 and holds at 15.
- Reset mid-stream: rst=1 with valid instructions in all stages plus stall=1 → all outputs 0 next cycle; the pipeline refills normally afterwards.
